// File: rtl/rsa_west_feeder.sv
// rsa_west_feeder: buffers X operand rows of N elements and streams them skewed into a systolic array's west edge
module rsa_west_feeder #(
  parameter int X      = 3,
  parameter int N      = 4,
  parameter int IN_LEN = 8
) (
  input  logic                clk,
  input  logic                sys_rst_n,
  input  logic [IN_LEN-1:0]   wr_data,
  input  logic [X:1]          wr_en,
  input  logic                start,
  output logic [X*IN_LEN-1:0] west_out,
  output logic [X:1]          west_val,
  output logic                load_full,
  output logic                busy,
  output logic                done
);
  localparam int PW   = $clog2(N + 1);
  localparam int AW   = N > 1 ? $clog2(N) : 1;
  localparam int TW   = $clog2(N + X);
  localparam int LAST = N + X - 2;
  typedef enum logic [1:0] {LOAD, STREAM, FIN} state_t;
  state_t              state_q, state_d;
  logic [TW-1:0]       t_q, t_d;
  logic [PW-1:0]       ptr_q [X];
  logic [IN_LEN-1:0]   mem_q [X][N];
  logic [X*IN_LEN-1:0] out_d;
  logic [X:1]          val_d, full, we;
  int                  k;
  always_comb begin
    for (int r = 0; r < X; r++) begin
      full[r+1] = ptr_q[r] == PW'(N);
      we[r+1]   = state_q == LOAD && wr_en[r+1] && !full[r+1];
    end
  end
  assign load_full = &full;
  assign busy      = state_q == STREAM;
  assign done      = state_q == FIN;
  always_ff @(posedge clk) begin
    state_q <= !sys_rst_n ? LOAD : state_d;
    t_q     <= !sys_rst_n ? '0 : t_d;
  end
  always_comb begin
    state_d = state_q == LOAD   ? (start && load_full ? STREAM : LOAD) :
              state_q == STREAM ? (t_q == TW'(LAST) ? FIN : STREAM) : LOAD;
    t_d     = state_q == STREAM && t_q != TW'(LAST) ? t_q + 1'b1 : '0;
  end
  // Outputs are computed from next state so row 1 element 0 shows right after the accepting edge.
  always_comb begin
    out_d = '0;
    val_d = '0;
    k     = 0;
    for (int r = 0; r < X; r++) begin
      k          = int'(t_d) - r;
      val_d[r+1] = state_d == STREAM && k >= 0 && k < N;
      out_d[r*IN_LEN +: IN_LEN] = val_d[r+1] ? mem_q[r][AW'(k)] : '0;
    end
  end
  always_ff @(posedge clk) begin
    west_out <= !sys_rst_n ? '0 : out_d;
    west_val <= !sys_rst_n ? '0 : val_d;
  end
  always_ff @(posedge clk) begin
    for (int r = 0; r < X; r++) begin
      if (!sys_rst_n || state_q == FIN) ptr_q[r] <= '0;
      else if (we[r+1]) ptr_q[r] <= ptr_q[r] + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    for (int r = 0; r < X; r++)
      if (we[r+1]) mem_q[r][ptr_q[r][AW-1:0]] <= wr_data;
  end
endmodule

// File: tb/tb_rsa_west_feeder.sv
// tb_rsa_west_feeder: randomized and directed checks of the west feeder against a row-queue model
module tb_rsa_west_feeder;
  localparam int X  = 3;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int NC = N + X + 1;
  logic           clk = 1'b0;
  logic           sys_rst_n;
  logic [W-1:0]   wr_data;
  logic [X:1]     wr_en;
  logic           start;
  logic [X*W-1:0] west_out;
  logic [X:1]     west_val;
  logic           load_full, busy, done;
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0]   mdl [X][N];
  int             mcnt [X];
  logic [X*W-1:0] cap_out [NC];
  logic [X:1]     cap_val [NC];
  logic           cap_busy [NC], cap_done [NC], cap_full [NC];
  always #5 clk = ~clk;
  rsa_west_feeder #(.X(X), .N(N), .IN_LEN(W)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .wr_data(wr_data), .wr_en(wr_en), .start(start),
    .west_out(west_out), .west_val(west_val), .load_full(load_full), .busy(busy), .done(done)
  );
  // Stream cycle c: row r shows its element c-r; cycle N+X-1 is the done cycle.
  function automatic logic [X*W-1:0] exp_out(int c);
    logic [X*W-1:0] v = '0;
    for (int r = 0; r < X; r++)
      if (c < N + X - 1 && c - r >= 0 && c - r < N) v[r*W +: W] = mdl[r][c-r];
    return v;
  endfunction
  function automatic logic [X:1] exp_val(int c);
    logic [X:1] v = '0;
    for (int r = 0; r < X; r++)
      if (c < N + X - 1 && c - r >= 0 && c - r < N) v[r+1] = 1'b1;
    return v;
  endfunction
  function automatic bit mfull();
    for (int r = 0; r < X; r++) if (mcnt[r] != N) return 1'b0;
    return 1'b1;
  endfunction
  task automatic do_write(input logic [X:1] en, input logic [W-1:0] d);
    @(negedge clk);
    wr_en = en;
    wr_data = d;
    for (int r = 0; r < X; r++)
      if (en[r+1] && mcnt[r] < N) begin
        mdl[r][mcnt[r]] = d;
        mcnt[r]++;
      end
    @(posedge clk);
    #1 wr_en = '0;
  endtask
  task automatic load_seq(input int base);
    logic [X:1] en;
    for (int r = 0; r < X; r++)
      for (int i = 0; i < N; i++) begin
        en = '0;
        en[r+1] = 1'b1;
        do_write(en, W'(base + r * N + i));
      end
  endtask
  task automatic run_capture(input bit hold);
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < NC; c++) begin
      @(posedge clk);
      #1;
      cap_out[c] = west_out;
      cap_val[c] = west_val;
      cap_busy[c] = busy;
      cap_done[c] = done;
      cap_full[c] = load_full;
      if (!hold) start = 1'b0;
    end
    start = 1'b0;
    for (int r = 0; r < X; r++) mcnt[r] = 0;
  endtask
  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (west_out !== '0) begin n_bad++; $display("FAIL reset_out got %h exp 0", west_out); end
    n_cmp++; if (west_val !== '0) begin n_bad++; $display("FAIL reset_val got %b exp 0", west_val); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", done); end
    n_cmp++; if (load_full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b exp 0", load_full); end
    @(negedge clk);
    sys_rst_n = 1'b1;
  endtask
  task automatic test_basic();
    load_seq(1);
    n_cmp++; if (load_full !== 1'b1) begin n_bad++; $display("FAIL basic_full got %b exp 1", load_full); end
    run_capture(1'b0);
    for (int c = 0; c < NC; c++) begin
      n_cmp++;
      if (cap_out[c] !== exp_out(c) || cap_val[c] !== exp_val(c) || cap_busy[c] !== (c < N + X - 1) ||
          cap_done[c] !== (c == N + X - 1) || cap_full[c] !== (c < N + X)) begin
        n_bad++;
        $display("FAIL basic c=%0d got out=%h val=%b busy=%b done=%b full=%b exp out=%h val=%b busy=%b done=%b full=%b",
                 c, cap_out[c], cap_val[c], cap_busy[c], cap_done[c], cap_full[c],
                 exp_out(c), exp_val(c), c < N + X - 1, c == N + X - 1, c < N + X);
      end
    end
  endtask
  task automatic test_partial();
    logic [X:1] en;
    for (int i = 0; i < X * N - 1; i++) begin
      en = '0;
      en[i / N + 1] = 1'b1;
      do_write(en, W'(i + 1));
    end
    n_cmp++; if (load_full !== 1'b0) begin n_bad++; $display("FAIL partial_full got %b exp 0", load_full); end
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 start = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || west_val !== '0) begin
        n_bad++;
        $display("FAIL partial_ignored c=%0d got busy=%b val=%b exp busy=0 val=0", c, busy, west_val);
      end
    end
    en = '0;
    en[X] = 1'b1;
    do_write(en, W'(X * N));
    n_cmp++; if (load_full !== 1'b1) begin n_bad++; $display("FAIL partial_full12 got %b exp 1", load_full); end
    run_capture(1'b0);
    for (int c = 0; c < NC; c++) begin
      n_cmp++;
      if (cap_out[c] !== exp_out(c) || cap_val[c] !== exp_val(c) || cap_busy[c] !== (c < N + X - 1) ||
          cap_done[c] !== (c == N + X - 1) || cap_full[c] !== (c < N + X)) begin
        n_bad++;
        $display("FAIL partial c=%0d got out=%h val=%b busy=%b done=%b exp out=%h val=%b",
                 c, cap_out[c], cap_val[c], cap_busy[c], cap_done[c], exp_out(c), exp_val(c));
      end
    end
  endtask
  task automatic test_overflow();
    load_seq(1);
    do_write(X'(1), 8'hFF);
    n_cmp++; if (load_full !== 1'b1) begin n_bad++; $display("FAIL overflow_full got %b exp 1", load_full); end
    run_capture(1'b0);
    for (int c = 0; c < NC; c++) begin
      n_cmp++;
      if (cap_out[c] !== exp_out(c) || cap_val[c] !== exp_val(c) || cap_done[c] !== (c == N + X - 1)) begin
        n_bad++;
        $display("FAIL overflow c=%0d got out=%h val=%b done=%b exp out=%h val=%b done=%b",
                 c, cap_out[c], cap_val[c], cap_done[c], exp_out(c), exp_val(c), c == N + X - 1);
      end
    end
  endtask
  task automatic test_broadcast();
    repeat (N) do_write('1, 8'hAA);
    run_capture(1'b0);
    for (int c = 0; c < NC; c++) begin
      n_cmp++;
      if (cap_out[c] !== exp_out(c) || cap_val[c] !== exp_val(c) || cap_busy[c] !== (c < N + X - 1)) begin
        n_bad++;
        $display("FAIL broadcast c=%0d got out=%h val=%b busy=%b exp out=%h val=%b busy=%b",
                 c, cap_out[c], cap_val[c], cap_busy[c], exp_out(c), exp_val(c), c < N + X - 1);
      end
    end
  endtask
  task automatic test_reset_mid();
    load_seq(1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    sys_rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (west_out !== '0 || west_val !== '0 || busy !== 1'b0 || load_full !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid got out=%h val=%b busy=%b full=%b done=%b exp all 0",
               west_out, west_val, busy, load_full, done);
    end
    for (int r = 0; r < X; r++) mcnt[r] = 0;
    @(negedge clk);
    sys_rst_n = 1'b1;
    start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1 start = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || west_val !== '0) begin
        n_bad++;
        $display("FAIL reset_mid_after c=%0d got busy=%b done=%b val=%b exp 0 0 0", c, busy, done, west_val);
      end
    end
  endtask
  task automatic test_start_held();
    load_seq(21);
    run_capture(1'b1);
    for (int c = 0; c < NC; c++) begin
      n_cmp++;
      if (cap_out[c] !== exp_out(c) || cap_val[c] !== exp_val(c) || cap_busy[c] !== (c < N + X - 1) ||
          cap_done[c] !== (c == N + X - 1) || cap_full[c] !== (c < N + X)) begin
        n_bad++;
        $display("FAIL start_held c=%0d got out=%h val=%b busy=%b done=%b full=%b exp out=%h val=%b",
                 c, cap_out[c], cap_val[c], cap_busy[c], cap_done[c], cap_full[c], exp_out(c), exp_val(c));
      end
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL start_held_after got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask
  task automatic test_random();
    for (int round = 0; round < 5; round++) begin
      for (int it = 0; it < 200 && !mfull(); it++) begin
        do_write(X'($urandom_range(1, (1 << X) - 1)), W'($urandom));
        n_cmp++;
        if (load_full !== mfull()) begin
          n_bad++;
          $display("FAIL random_full r=%0d got %b exp %b", round, load_full, mfull());
        end
      end
      run_capture(1'b0);
      for (int c = 0; c < NC; c++) begin
        n_cmp++;
        if (cap_out[c] !== exp_out(c) || cap_val[c] !== exp_val(c) || cap_done[c] !== (c == N + X - 1)) begin
          n_bad++;
          $display("FAIL random r=%0d c=%0d got out=%h val=%b done=%b exp out=%h val=%b done=%b",
                   round, c, cap_out[c], cap_val[c], cap_done[c], exp_out(c), exp_val(c), c == N + X - 1);
        end
      end
    end
  endtask
  initial begin
    sys_rst_n = 1'b0;
    wr_en = '0;
    wr_data = '0;
    start = 1'b0;
    for (int r = 0; r < X; r++) mcnt[r] = 0;
    test_reset();
    test_basic();
    test_partial();
    test_overflow();
    test_broadcast();
    test_reset_mid();
    test_start_held();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rsa_west_feeder.md
RSA_WEST_FEEDER -- requirements
Module: rsa_west_feeder

Interface
REQ-001 Parameter X, default 3: number of systolic-array rows fed from the west.
REQ-002 Parameter N, default 4: elements per row per operand, i.e. the inner dimension.
REQ-003 Parameter IN_LEN, default 8: element width in bits.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 sys_rst_n  input  1  reset, synchronous, active-low.
REQ-006 wr_data  input  IN_LEN  element to store.
REQ-007 wr_en  input  X (bits X:1)  row write enables; bit r writes wr_data into row buffer r.
REQ-008 start  input  1  single-cycle request to begin skewed streaming.
REQ-009 west_out  output  X*IN_LEN  row r data on bits [r*IN_LEN-1:(r-1)*IN_LEN].
REQ-010 west_val  output  X (bits X:1)  per-row valid for west_out.
REQ-011 load_full  output  1  high when every row buffer holds N elements.
REQ-012 busy  output  1  high while in STREAM.
REQ-013 done  output  1  one-cycle pulse at end of stream.

Function
REQ-014 The block SHALL hold X row buffers of depth N, each with its own write pointer of width ceil(log2(N+1)).
REQ-015 The FSM SHALL have states LOAD, STREAM and FIN; it SHALL leave reset in LOAD.
REQ-016 In LOAD, each row r with wr_en[r]=1 and pointer<N SHALL store wr_data at the pointer and then increment the pointer.
REQ-017 A write to a full row, or any write outside LOAD, SHALL be dropped silently with no pointer change.
REQ-018 Multiple wr_en bits set in one cycle SHALL write the same wr_data into each selected non-full row.
REQ-019 load_full SHALL be combinational: high exactly when all X pointers equal N.
REQ-020 In LOAD, start=1 with load_full=1 SHALL move the FSM to STREAM and clear stream counter t to 0; start with load_full=0 SHALL be ignored.
REQ-021 In STREAM, t SHALL advance by 1 each cycle, running from 0 to N+X-2; STREAM therefore lasts N+X-1 cycles.
REQ-022 Outputs SHALL be registered: in STREAM cycle t, row r SHALL present element k=t-(r-1) with west_val[r]=1 when 0<=k<N; otherwise west_out row r SHALL be 0 and west_val[r]=0.
REQ-023 Row 1 element 0 SHALL appear in the first cycle after the edge at which start is accepted; row r lags row r-1 by exactly one cycle.
REQ-024 At t=N+X-2 the FSM SHALL go to FIN; FIN SHALL last one cycle with done=1, west_val=0 and west_out=0.
REQ-025 On leaving FIN, all write pointers SHALL clear to 0 and the FSM SHALL return to LOAD.
REQ-026 busy SHALL be 1 exactly in STREAM.
REQ-027 start asserted in STREAM or FIN SHALL be ignored.
REQ-028 Outside STREAM, west_val SHALL be 0 and west_out SHALL be 0.

Reset
REQ-029 While sys_rst_n=0 at a clock edge, the block SHALL return to LOAD and clear all pointers and t.
REQ-030 The same reset edge SHALL set west_out=0, west_val=0, busy=0 and done=0; buffer contents are don't-care.
REQ-031 Reset asserted mid-STREAM SHALL abort the stream with no done pulse; the next stream requires a full reload.

Verification (X=3, N=4, IN_LEN=8)
REQ-032 Load row1=1,2,3,4, row2=5..8, row3=9..12, then start -> load_full=1 before start; row1 gives 1,2,3,4 in cycles 0-3, row2 gives 5-8 in cycles 1-4, row3 gives 9-12 in cycles 2-5; done pulses in cycle 6.
REQ-033 Load only 11 elements, then start -> ignored, busy=0, west_val=0; after the 12th write and a second start, streaming proceeds as in REQ-032.
REQ-034 Write a 5th element 0xFF to full row 1 -> dropped; row 1 still streams 1,2,3,4.
REQ-035 wr_en=3'b111 with data 0xAA for 4 cycles -> all rows stream 0xAA, staggered by one cycle each.
REQ-036 Reset at STREAM cycle 2 -> next cycle outputs 0, busy=0, load_full=0, no done; start then ignored until reloaded.
REQ-037 start held high for the whole stream -> exactly one stream and one done pulse; the FSM then sits in LOAD with load_full=0.
